// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes decoded by jump control and the interrupt
// requester, the ISR entry vector, and the interrupt FSM state type.
package cpu_pkg;

    localparam logic [4:0] OPC_RET = 5'b10000;
    localparam logic [4:0] OPC_JMP = 5'b11000;
    localparam logic [4:0] OPC_JC  = 5'b11001;
    localparam logic [4:0] OPC_JNC = 5'b11010;
    localparam logic [4:0] OPC_JZ  = 5'b11011;
    localparam logic [4:0] OPC_JNZ = 5'b11100;

    localparam logic [7:0] ISR_VECTOR = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2,
        RETURN  = 2'd3
    } irq_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder for eligible interrupt lines; lowest index wins.
module irq_priority_enc #(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 2
) (
    input  logic [NUM_IRQ-1:0]  i_eligible,
    output logic                o_valid,
    output logic [IRQ_ID_W-1:0] o_id
);

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_valid = 1'b1;
                o_id    = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt requester for jump control: mask, fixed priority, one-cycle issue
// pulse, RET-terminated service window. Define IRQ_EDGE_DETECT_EN for sticky
// rising-edge capture instead of level capture.
module irq_controller
    import cpu_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_req,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    input  logic [19:0]         ins,
    input  logic                jump_taken,
    output logic                interrupt,
    output logic                irq_active,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [NUM_IRQ-1:0]  irq_pending
);

    irq_state_t            r_state;
    irq_state_t            w_state_nxt;
    logic [NUM_IRQ-1:0]    r_pending;
    logic                  r_interrupt;
    logic                  r_active;
    logic [IRQ_ID_W-1:0]   r_id;

    logic                  w_ret;
    logic                  w_accept;
    logic                  w_valid;
    logic [IRQ_ID_W-1:0]   w_win_id;
    logic [NUM_IRQ-1:0]    w_eligible;
    logic [NUM_IRQ-1:0]    w_clear;

    assign w_ret      = (ins[19:15] == OPC_RET);
    assign w_eligible = r_pending & irq_mask;
    assign w_clear    = w_accept ? (NUM_IRQ'(1) << w_win_id) : '0;

    irq_priority_enc #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_ID_W (IRQ_ID_W)
    ) u_prio (
        .i_eligible (w_eligible),
        .o_valid    (w_valid),
        .o_id       (w_win_id)
    );

    // Never issue while jump control is redirecting or a RET is in decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid && !jump_taken && !w_ret) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE:   w_state_nxt = SERVICE;
            SERVICE: if (w_ret) w_state_nxt = RETURN;
            RETURN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_interrupt <= 1'b0;
            r_active    <= 1'b0;
            r_id        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_interrupt <= (w_state_nxt == ISSUE);
            r_active    <= (w_state_nxt == SERVICE);
            if (w_accept) begin
                r_id <= w_win_id;
            end
        end
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] r_req_prev;

    // Rising edge sets the sticky bit; a set in the accept cycle beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_req_prev <= irq_req;
            r_pending  <= (r_pending & ~w_clear) | (irq_req & ~r_req_prev);
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= irq_req & ~w_clear;
        end
    end
`endif

    assign interrupt   = r_interrupt;
    assign irq_active  = r_active;
    assign irq_id      = r_id;
    assign irq_pending = r_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_irq_controller;

    localparam int NUM_IRQ  = 4;
    localparam int IRQ_ID_W = 2;
    localparam logic [19:0] INS_NOP = 20'h00000;
    localparam logic [19:0] INS_RET = 20'h80000;

    logic                clk;
    logic                reset;
    logic [NUM_IRQ-1:0]  irq_req;
    logic [NUM_IRQ-1:0]  irq_mask;
    logic [19:0]         ins;
    logic                jump_taken;
    logic                interrupt;
    logic                irq_active;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [NUM_IRQ-1:0]  irq_pending;

    int n_cmp;
    int n_bad;

    irq_controller #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_ID_W (IRQ_ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_req     (irq_req),
        .irq_mask    (irq_mask),
        .ins         (ins),
        .jump_taken  (jump_taken),
        .interrupt   (interrupt),
        .irq_active  (irq_active),
        .irq_id      (irq_id),
        .irq_pending (irq_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: "busy" is the union of pulse cycle, service window and guard cycle.
    logic                m_int;
    logic                m_act;
    logic                m_guard;
    int                  m_id;
    logic [NUM_IRQ-1:0]  m_pend;
    logic [NUM_IRQ-1:0]  m_prev;

    always @(posedge clk or negedge reset) begin : model
        logic [NUM_IRQ-1:0] elig;
        logic [NUM_IRQ-1:0] clr;
        logic found, busy, is_ret, take;
        int   win;
        if (!reset) begin
            m_int   <= 1'b0;
            m_act   <= 1'b0;
            m_guard <= 1'b0;
            m_id    <= 0;
            m_pend  <= '0;
            m_prev  <= '0;
        end else begin
            elig  = m_pend & irq_mask;
            found = 1'b0;
            win   = 0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (elig[i] && !found) begin
                    found = 1'b1;
                    win   = i;
                end
            end
            is_ret = (ins[19:15] == 5'b10000);
            busy   = m_int || m_act || m_guard;
            take   = !busy && found && !jump_taken && !is_ret;
            clr    = '0;
            if (take) clr[win] = 1'b1;
`ifdef IRQ_EDGE_DETECT_EN
            m_pend <= (m_pend & ~clr) | (irq_req & ~m_prev);
            m_prev <= irq_req;
`else
            m_pend <= irq_req & ~clr;
`endif
            m_int   <= take;
            m_act   <= m_int || (m_act && !is_ret);
            m_guard <= m_act && is_ret;
            if (take) m_id <= win;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drop requests, let the ISR run briefly, then RET and wait out the guard cycle.
    task automatic finish_service();
        irq_req = '0;
        step();
        chk("svc_active", int'(irq_active), 1);
        step();
        ins = INS_RET;
        step();
        ins = INS_NOP;
        chk("ret_active_low", int'(irq_active), 0);
        chk("ret_no_int", int'(interrupt), 0);
        step();
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b0;
        irq_req    = '0;
        irq_mask   = '0;
        ins        = INS_NOP;
        jump_taken = 1'b0;

        fork
            forever begin
                @(negedge clk);
                chk("model_interrupt", int'(interrupt), int'(m_int));
                chk("model_active", int'(irq_active), int'(m_act));
                chk("model_id", int'(irq_id), m_id);
                chk("model_pending", int'(irq_pending), int'(m_pend));
            end
        join_none

        repeat (2) step();
        chk("rst_interrupt", int'(interrupt), 0);
        chk("rst_active", int'(irq_active), 0);
        chk("rst_id", int'(irq_id), 0);
        chk("rst_pending", int'(irq_pending), 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("quiet_interrupt", int'(interrupt), 0);
            chk("quiet_active", int'(irq_active), 0);
        end

        // Single source, id 2, one clock of latency.
        irq_mask = 4'b1111;
        irq_req  = 4'b0100;
        step();
        chk("single_pending", int'(irq_pending), 4'b0100);
        chk("single_no_int_yet", int'(interrupt), 0);
        step();
        chk("single_int", int'(interrupt), 1);
        chk("single_id", int'(irq_id), 2);
        finish_service();
        chk("single_id_held", int'(irq_id), 2);

        // Two sources together: 1 then 3.
        irq_req = 4'b1010;
        step();
        step();
        chk("pair_first_int", int'(interrupt), 1);
        chk("pair_first_id", int'(irq_id), 1);
        irq_req = 4'b1000;
        step();
        step();
        ins = INS_RET;
        step();
        ins = INS_NOP;
        chk("pair_guard_active", int'(irq_active), 0);
        step();
        chk("pair_idle_no_int", int'(interrupt), 0);
        step();
        chk("pair_second_int", int'(interrupt), 1);
        chk("pair_second_id", int'(irq_id), 3);
        finish_service();

        // Request deferred while jump_taken is high.
        jump_taken = 1'b1;
        irq_req    = 4'b0001;
        step();
        step();
        chk("jt_no_int", int'(interrupt), 0);
        jump_taken = 1'b0;
        step();
        chk("jt_deferred_int", int'(interrupt), 1);
        chk("jt_deferred_id", int'(irq_id), 0);
        finish_service();

        // Masked line stays pending, issues once unmasked.
        irq_mask = 4'b1110;
        irq_req  = 4'b0001;
        repeat (3) step();
        chk("mask_no_int", int'(interrupt), 0);
        chk("mask_pending", int'(irq_pending), 4'b0001);
        irq_mask = 4'b1111;
        step();
        chk("unmask_int", int'(interrupt), 1);
        chk("unmask_id", int'(irq_id), 0);
        finish_service();

        // Asynchronous reset in the middle of a service window.
        irq_req = 4'b0010;
        step();
        step();
        chk("mid_int", int'(interrupt), 1);
        step();
        chk("mid_active", int'(irq_active), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_active", int'(irq_active), 0);
        chk("async_interrupt", int'(interrupt), 0);
        chk("async_pending", int'(irq_pending), 0);
        chk("async_id", int'(irq_id), 0);
        irq_req = '0;
        step();
        reset = 1'b1;
        repeat (2) step();

        // One-cycle pulse on line 3 yields exactly one interrupt.
        irq_req = 4'b1000;
        step();
        irq_req = 4'b0000;
        step();
        chk("pulse_int", int'(interrupt), 1);
        chk("pulse_id", int'(irq_id), 3);
        step();
        ins = INS_RET;
        step();
        ins = INS_NOP;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pulse_no_refire", int'(interrupt), 0);
        end

`ifdef IRQ_EDGE_DETECT_EN
        // Held high through RET must not re-fire.
        irq_req = 4'b0100;
        step();
        step();
        chk("hold_int", int'(interrupt), 1);
        step();
        ins = INS_RET;
        step();
        ins = INS_NOP;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_no_refire", int'(interrupt), 0);
        end
        irq_req = '0;
        step();
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
